// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential binary-to-BCD converter (double dabble, one bit per clock)
// Valid/ready on both sides; each result is held in DONE until the consumer takes it.
module bcd_seq_converter #(
  parameter int IN_W  = 13,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [3:0]      thousands,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);

  generate
    if (IN_W < 1 || IN_W > 13) begin : g_bad_in_w
      $error("bcd_seq_converter: IN_W must be in 1..13");
    end
    if ((1 << CNT_W) <= IN_W) begin : g_bad_cnt_w
      $error("bcd_seq_converter: CNT_W too narrow for IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        th_q, th_d, hu_q, hu_d, te_q, te_d, on_q, on_d;

  // Thousands bit 3 is always shifted out as 0, so only its low 3 bits are kept.
  logic [2:0]        th_c;
  logic [3:0]        hu_c, te_c, on_c;

  assign th_c = th_q[2:0] + ((th_q >= 4'd5) ? 3'd3 : 3'd0);
  assign hu_c = (hu_q >= 4'd5) ? hu_q + 4'd3 : hu_q;
  assign te_c = (te_q >= 4'd5) ? te_q + 4'd3 : te_q;
  assign on_c = (on_q >= 4'd5) ? on_q + 4'd3 : on_q;

  assign in_ready  = (state_q == IDLE) & rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign thousands = th_q;
  assign hundreds  = hu_q;
  assign tens      = te_q;
  assign ones      = on_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    th_d    = th_q;
    hu_d    = hu_q;
    te_d    = te_q;
    on_d    = on_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sh_d    = bin;
          cnt_d   = CNT_W'(IN_W - 1);
          th_d    = 4'd0;
          hu_d    = 4'd0;
          te_d    = 4'd0;
          on_d    = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        th_d = {th_c, hu_c[3]};
        hu_d = {hu_c[2:0], te_c[3]};
        te_d = {te_c[2:0], on_c[3]};
        on_d = {on_c[2:0], sh_q[IN_W-1]};
        sh_d = sh_q << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      th_q    <= 4'd0;
      hu_q    <= 4'd0;
      te_q    <= 4'd0;
      on_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      th_q    <= th_d;
      hu_q    <= hu_d;
      te_q    <= te_d;
      on_q    <= on_d;
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - self-checking bench for bcd_seq_converter
// Directed and random conversions compared against decimal arithmetic on the input value.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [12:0] bin;
  logic [3:0]  thousands, hundreds, tens, ones;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  bin8;
  logic [3:0]  th8, hu8, te8, on8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_seq_converter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  bcd_seq_converter #(.IN_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .bin(bin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8),
    .thousands(th8), .hundreds(hu8), .tens(te8), .ones(on8)
  );

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept v, then wait (bounded) for out_valid; noise drives 7777 on the input while busy.
  task automatic run13(input int v, input bit noise);
    int lat, busy_n;
    bit seen;
    check("in_ready_before_accept", in_ready, 1);
    bin = 13'(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bin = 13'($urandom);
    if (noise) begin
      in_valid = 1'b1;
      bin = 13'd7777;
    end
    lat = 0;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy) busy_n++;
      check("in_ready_while_busy", in_ready, 0);
      step();
      lat++;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    check("latency", lat, 13);
    check("busy_cycles", busy_n, 13);
    check("in_ready_in_done", in_ready, 0);
    check("digits", {thousands, hundreds, tens, ones}, ref_bcd(v));
  endtask

  task automatic release13();
    out_ready = 1'b1;
    step();
    check("out_valid_after_take", out_valid, 0);
    check("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run8(input int v);
    int lat;
    bit seen;
    step();
    check("in_ready8_before_accept", in_ready8, 1);
    bin8 = 8'(v);
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    bin8 = 8'($urandom);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      lat++;
      if (out_valid8) seen = 1'b1;
    end
    check("latency8", lat, 8);
    check("digits8", {th8, hu8, te8, on8}, ref_bcd(v));
  endtask

  initial begin
    int sweep [10] = '{0, 9, 10, 99, 100, 1234, 5555, 8190, 8191, 1};
    bit seen;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    bin = '0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    bin8 = '0;
    step();
    step();
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_digits", {thousands, hundreds, tens, ones}, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    run13(8191, 1'b0);
    release13();

    foreach (sweep[k]) begin
      out_ready = 1'b1;
      run13(sweep[k], 1'b0);
      release13();
    end

    for (int k = 0; k < 60; k++) begin
      out_ready = 1'b1;
      run13(int'($urandom_range(0, 8191)), 1'b0);
      release13();
    end

    out_ready = 1'b0;
    run13(4096, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_digits", {thousands, hundreds, tens, ones}, ref_bcd(4096));
    end
    release13();
    out_ready = 1'b0;

    run13(2025, 1'b1);
    release13();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("no_extra_result", seen, 0);

    bin = 13'd3000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_digits", {thousands, hundreds, tens, ones}, 0);
    check("midreset_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("no_result_3000", seen, 0);
    out_ready = 1'b1;
    run13(42, 1'b0);
    release13();

    run8(255);
    for (int k = 0; k < 6; k++) begin
      run8(int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
